prog_mem: RTL and testbench
===========================

PROG_MEM -- requirements
Module: prog_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of one program word.
REQ-002 SHALL have parameter ADDR_W, default 16: width of all address and length ports.
REQ-003 SHALL have parameter DEPTH, default 256: number of stored words, from 1 to 2^ADDR_W.
REQ-004 SHALL have parameter READ_LAT, default 1: read latency in cycles; legal values are 1 and 2.
REQ-005 SHALL have parameter FILL, default 0: value returned for out-of-range reads and used as power-up contents.
REQ-006 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port rd_en, input, 1 bit: read request.
REQ-009 SHALL have port rd_addr, input, ADDR_W bits: read word address.
REQ-010 SHALL have port rd_data, output, DATA_W bits: read result.
REQ-011 SHALL have port rd_valid, output, 1 bit: rd_data is updated this cycle.
REQ-012 SHALL have port ld_start, input, 1 bit: starts a load burst.
REQ-013 SHALL have port ld_base, input, ADDR_W bits: first word address of the burst.
REQ-014 SHALL have port ld_len, input, ADDR_W bits: number of words in the burst.
REQ-015 SHALL have port ld_valid, input, 1 bit: ld_data is valid.
REQ-016 SHALL have port ld_data, input, DATA_W bits: word to be written.
REQ-017 SHALL have port ld_ready, output, 1 bit: the block accepts a load word.
REQ-018 SHALL have port busy, output, 1 bit: the load FSM is not in IDLE.
REQ-019 SHALL have port ld_done, output, 1 bit: one-cycle pulse at the end of a burst.
REQ-020 SHALL have port ld_err, output, 1 bit: sticky flag for an out-of-range load write.

Function
REQ-021 Read path:
- rd_en sampled high at edge N SHALL give rd_data = mem[rd_addr] with rd_valid = 1 after edge N+READ_LAT-1.
- Reads SHALL be fully pipelined: one request per cycle, no stalls.
REQ-022 rd_addr >= DEPTH SHALL return FILL with rd_valid = 1; there is no wrap.
REQ-023 When no read completes, rd_data SHALL hold its last value and rd_valid SHALL be 0.
REQ-024 FSM states SHALL be IDLE, LOAD and DONE; busy = (state != IDLE).
REQ-025 IDLE transitions:
- ld_start with ld_len != 0 SHALL go to LOAD, set ptr = ld_base and cnt = ld_len.
- ld_start with ld_len == 0 SHALL go directly to DONE.
REQ-026 ld_start SHALL be ignored in LOAD and DONE.
REQ-027 ld_ready SHALL be 1 only in LOAD.
REQ-028 A word transfers when ld_valid and ld_ready are both 1 at an edge. On each transfer:
- write mem[ptr] = ld_data;
- ptr increments by 1 and wraps modulo 2^ADDR_W;
- cnt decrements by 1.
REQ-029 A transfer with ptr >= DEPTH SHALL be accepted but the write discarded, and ld_err SHALL be set.
REQ-030 ld_err SHALL stay set until reset or the next accepted ld_start.
REQ-031 The transfer with cnt == 1 SHALL move the FSM to DONE.
REQ-032 DONE SHALL last exactly one cycle with ld_done = 1, then return to IDLE.
REQ-033 Reads SHALL be serviced in every state. A read and a write to the same address at the same edge SHALL return the old data; the new data is visible from the next read.
REQ-034 ld_valid with ld_ready = 0 SHALL have no effect.

Reset
REQ-035 rst high SHALL immediately force:
- FSM to IDLE;
- rd_data = 0, rd_valid = 0;
- ld_ready = 0, busy = 0, ld_done = 0, ld_err = 0;
- read pipeline flushed.
REQ-036 Reset SHALL NOT alter memory contents. Power-up contents are FILL.
REQ-037 Reset during LOAD SHALL abort the burst; words already written SHALL be retained.

Verification
REQ-038 Load burst: with defaults, ld_start with base 0 and len 3, then words 1300h, 1400h, 1500h with ld_valid held high.
- Response: ld_ready high for 3 cycles, ld_done pulses once.
- Reads of addresses 0, 1, 2 then return 1300h, 1400h, 1500h, each 1 cycle after rd_en.
REQ-039 Pipelined reads: READ_LAT = 2, back-to-back rd_en on addresses 0, 1, 2.
- Response: rd_valid high for 3 consecutive cycles starting 2 cycles after the first request; data in request order.
REQ-040 Out-of-range: read address 300 -> FILL. Load with base 254, len 4 -> ld_err set; addresses 254 and 255 written; nothing else changes.
REQ-041 Zero length and protocol corners:
- ld_len = 0: DONE for one cycle with ld_done = 1, no writes.
- ld_start during LOAD: ignored.
- ld_valid toggling: only handshaked words are written.
REQ-042 Reset and hazards:
- rst asserted after 2 of 4 words: FSM goes to IDLE asynchronously, both words are retained, outputs are 0.
- Same-address read and write at one edge: the read returns the old value.

Source files
------------

// File: rtl/prog_mem.sv
// Program memory with a pipelined read port and a burst-load write port.
// Ports: clk/rst; read: rd_en, rd_addr -> rd_data, rd_valid (READ_LAT cycles);
//        load: ld_start, ld_base, ld_len, ld_valid/ld_data/ld_ready, busy, ld_done, ld_err.
module prog_mem #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                DEPTH    = 256,
  parameter int                READ_LAT = 1,
  parameter logic [DATA_W-1:0] FILL     = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W-1:0] ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              busy,
  output logic              ld_done,
  output logic              ld_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2^ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_e;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  // Contents are not reset; they come up as FILL and survive rst.
  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: FILL};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              s1_vld_q;
  logic [DATA_W-1:0] s1_dat_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [DATA_W-1:0] rd_word;
  logic              xfer;

  // Array is sampled before the same-edge write lands, so a colliding
  // read returns the old word.
  assign rd_word = in_range(rd_addr) ? mem_q[rd_addr[IDX_W-1:0]] : FILL;
  assign xfer    = ld_valid && (state_q == LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_dat_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else if (READ_LAT == 2) begin
      s1_vld_q   <= rd_en;
      if (rd_en) s1_dat_q <= rd_word;
      rd_valid_q <= s1_vld_q;
      if (s1_vld_q) rd_data_q <= s1_dat_q;
    end else begin
      s1_vld_q   <= 1'b0;
      rd_valid_q <= rd_en;
      if (rd_en) rd_data_q <= rd_word;
    end
  end

  // Out-of-range transfers are still handshaked; only the write is dropped.
  always_ff @(posedge clk) begin
    if (xfer && in_range(ptr_q)) mem_q[ptr_q[IDX_W-1:0]] <= ld_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (ld_start) begin
          err_d = 1'b0;
          if (ld_len != '0) begin
            state_d = LOAD;
            ptr_d   = ld_base;
            cnt_d   = ld_len;
          end else begin
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        if (ld_valid) begin
          if (!in_range(ptr_q)) err_d = 1'b1;
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == ADDR_W'(1)) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign ld_ready = (state_q == LOAD);
  assign busy     = (state_q != IDLE);
  assign ld_done  = (state_q == DONE);
  assign ld_err   = err_q;

endmodule

// File: tb/tb_prog_mem.sv
// Testbench for prog_mem: READ_LAT=1 and READ_LAT=2 instances share stimulus;
// reads are scored from queues, load-control outputs from a rule-level model.
module tb_prog_mem;
  localparam int          DW    = 16;
  localparam int          AW    = 16;
  localparam int          DEPTH = 256;
  localparam logic [15:0] FILL  = 16'hA5A5;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic          ld_start;
  logic [AW-1:0] ld_base;
  logic [AW-1:0] ld_len;
  logic          ld_valid;
  logic [DW-1:0] ld_data;

  logic [DW-1:0] rd_data1, rd_data2;
  logic          rd_valid1, rd_valid2;
  logic          ld_ready1, ld_ready2, busy1, busy2;
  logic          ld_done1, ld_done2, ld_err1, ld_err2;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  prog_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LAT(1), .FILL(FILL)) dut1 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data1), .rd_valid(rd_valid1),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready1),
    .busy(busy1), .ld_done(ld_done1), .ld_err(ld_err1));

  prog_mem #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LAT(2), .FILL(FILL)) dut2 (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data2), .rd_valid(rd_valid2),
    .ld_start(ld_start), .ld_base(ld_base), .ld_len(ld_len),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready2),
    .busy(busy2), .ld_done(ld_done2), .ld_err(ld_err2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: expected data plus the cycle count at which it must appear.
  typedef struct {
    logic [15:0] dat;
    int          cyc;
  } exp_t;
  exp_t q1[$];
  exp_t q2[$];

  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst) begin
      if (rd_valid1) begin
        if (q1.size() == 0) check("rd1_unexpected_valid", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          check("rd1_data", 32'(rd_data1), 32'(e.dat));
          check("rd1_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else if (q1.size() > 0 && q1[0].cyc <= cyc) begin
        check("rd1_missing_valid", 32'd0, 32'd1);
        void'(q1.pop_front());
      end
    end
  end

  always @(negedge clk) begin : mon2
    exp_t e;
    if (!rst) begin
      if (rd_valid2) begin
        if (q2.size() == 0) check("rd2_unexpected_valid", 32'd1, 32'd0);
        else begin
          e = q2.pop_front();
          check("rd2_data", 32'(rd_data2), 32'(e.dat));
          check("rd2_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else if (q2.size() > 0 && q2[0].cyc <= cyc) begin
        check("rd2_missing_valid", 32'd0, 32'd1);
        void'(q2.pop_front());
      end
    end
  end

  // Reference model: memory image plus load-burst bookkeeping.
  logic [15:0] mmem [DEPTH];
  int          mstate;   // 0 idle, 1 loading, 2 done pulse
  int          mptr;
  int          mcnt;
  bit          merr;

  task automatic idle_inputs();
    rd_en = 0; rd_addr = '0; ld_start = 0; ld_base = '0; ld_len = '0;
    ld_valid = 0; ld_data = '0;
  endtask

  task automatic check_ctrl(input string tag);
    check({tag, "_ld_ready1"}, 32'(ld_ready1), 32'(mstate == 1));
    check({tag, "_busy1"},     32'(busy1),     32'(mstate != 0));
    check({tag, "_ld_done1"},  32'(ld_done1),  32'(mstate == 2));
    check({tag, "_ld_err1"},   32'(ld_err1),   32'(merr));
    check({tag, "_ld_ready2"}, 32'(ld_ready2), 32'(mstate == 1));
    check({tag, "_busy2"},     32'(busy2),     32'(mstate != 0));
    check({tag, "_ld_done2"},  32'(ld_done2),  32'(mstate == 2));
    check({tag, "_ld_err2"},   32'(ld_err2),   32'(merr));
  endtask

  // One clock: enqueue read expectations, clock, advance model, check control.
  task automatic step(input string tag);
    if (rd_en) begin
      exp_t e;
      e.dat = (int'(rd_addr) < DEPTH) ? mmem[int'(rd_addr)] : FILL;
      e.cyc = cyc + 1;
      q1.push_back(e);
      e.cyc = cyc + 2;
      q2.push_back(e);
    end
    @(posedge clk);
    case (mstate)
      0: if (ld_start) begin
           merr = 0;
           if (ld_len != 0) begin mstate = 1; mptr = int'(ld_base); mcnt = int'(ld_len); end
           else mstate = 2;
         end
      1: if (ld_valid) begin
           if (mptr < DEPTH) mmem[mptr] = ld_data;
           else merr = 1;
           mptr = (mptr + 1) % 65536;
           mcnt = mcnt - 1;
           if (mcnt == 0) mstate = 2;
         end
      default: mstate = 0;
    endcase
    @(negedge clk);
    check_ctrl(tag);
  endtask

  task automatic read(input int a, input string tag);
    idle_inputs();
    rd_en = 1; rd_addr = AW'(a);
    step(tag);
  endtask

  task automatic drain();
    idle_inputs();
    repeat (4) step("drain");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_data1"},  32'(rd_data1),  32'd0);
    check({tag, "_rd_valid1"}, 32'(rd_valid1), 32'd0);
    check({tag, "_rd_data2"},  32'(rd_data2),  32'd0);
    check({tag, "_rd_valid2"}, 32'(rd_valid2), 32'd0);
    check({tag, "_ld_ready1"}, 32'(ld_ready1), 32'd0);
    check({tag, "_busy1"},     32'(busy1),     32'd0);
    check({tag, "_ld_done1"},  32'(ld_done1),  32'd0);
    check({tag, "_ld_err1"},   32'(ld_err1),   32'd0);
    check({tag, "_busy2"},     32'(busy2),     32'd0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) mmem[i] = FILL;
    mstate = 0; mptr = 0; mcnt = 0; merr = 0;
    rst = 1;
    idle_inputs();
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 0;

    // Power-up contents, then the basic three-word burst.
    read(0, "pwrup");
    idle_inputs();
    ld_start = 1; ld_base = 16'd0; ld_len = 16'd3;
    step("burst_start");
    idle_inputs();
    ld_valid = 1; ld_data = 16'h1300; step("burst_w0");
    ld_data = 16'h1400; step("burst_w1");
    ld_data = 16'h1500; step("burst_w2");
    idle_inputs();
    step("burst_done");
    read(0, "rd0"); read(1, "rd1"); read(2, "rd2");
    drain();

    // Out-of-range read and a burst straddling the top of memory.
    read(300, "rd_oor");
    idle_inputs();
    ld_start = 1; ld_base = 16'd254; ld_len = 16'd4;
    step("oor_start");
    idle_inputs();
    ld_valid = 1;
    for (int i = 0; i < 4; i++) begin
      ld_data = 16'h7700 + 16'(i);
      step("oor_w");
    end
    idle_inputs();
    step("oor_done");
    read(254, "rd254"); read(255, "rd255"); read(0, "rd0b"); read(1, "rd1b"); read(256, "rd256");
    drain();

    // Zero-length burst clears ld_err and pulses ld_done.
    idle_inputs();
    ld_start = 1; ld_base = 16'd5; ld_len = 16'd0;
    step("zlen_start");
    idle_inputs();
    step("zlen_done");
    read(5, "rd5");
    drain();

    // ld_start ignored during LOAD; ld_valid toggling.
    idle_inputs();
    ld_start = 1; ld_base = 16'd10; ld_len = 16'd3;
    step("ign_start");
    for (int i = 0; i < 8; i++) begin
      idle_inputs();
      ld_start = (i == 1); ld_base = 16'd50; ld_len = 16'd1;
      ld_valid = i[0]; ld_data = 16'h2000 + 16'(i);
      step("ign_load");
    end
    drain();
    read(10, "rd10"); read(11, "rd11"); read(12, "rd12"); read(50, "rd50");
    drain();

    // Same-address read and write at one edge returns the old word.
    idle_inputs();
    ld_start = 1; ld_base = 16'd20; ld_len = 16'd1;
    step("haz_start");
    idle_inputs();
    ld_valid = 1; ld_data = 16'hBEEF; rd_en = 1; rd_addr = 16'd20;
    step("haz_w");
    read(20, "haz_rd_new");
    drain();

    // Reset mid-burst after two of four words, with reads in flight.
    idle_inputs();
    ld_start = 1; ld_base = 16'd40; ld_len = 16'd4;
    step("rst_start");
    idle_inputs();
    ld_valid = 1; ld_data = 16'h4040; step("rst_w0");
    ld_data = 16'h4141; rd_en = 1; rd_addr = 16'd41; step("rst_w1");
    idle_inputs();
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    check_reset_outputs("midrst");
    q1.delete(); q2.delete();
    mstate = 0; merr = 0;
    @(negedge clk);
    rst = 0;
    check_ctrl("post_rst");
    read(40, "rd40"); read(41, "rd41"); read(42, "rd42");
    drain();

    // Randomized traffic, including bursts that wrap past 0xFFFF.
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      rd_en   = 1'($urandom_range(0, 1));
      rd_addr = AW'($urandom_range(0, 300));
      if ($urandom_range(0, 6) == 0) begin
        ld_start = 1;
        case ($urandom_range(0, 3))
          0:       ld_base = AW'($urandom_range(250, 255));
          1:       ld_base = AW'($urandom_range(65534, 65535));
          default: ld_base = AW'($urandom_range(0, 255));
        endcase
        ld_len = AW'($urandom_range(0, 6));
      end
      ld_valid = 1'($urandom_range(0, 3) != 0);
      ld_data  = DW'($urandom);
      step("rand");
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
